// File: rtl/keccak_theta_seq.sv
// keccak_theta_seq -- sequential Keccak-f[1600] theta stage.
//
// Accepts the 25 lanes of a state in ascending index order (i = x + 5*y). Each
// 64-bit lane arrives as a high/low 32-bit pair. One cycle then computes the
// five column parities and registers the theta D-terms. The 25 theta-mixed
// lanes are then streamed out, one per valid/ready handshake, together with
// their lane index.
//
// Optional feature macro: KECCAK_THETA_RHO_OFF_EN adds rot_off_o, which is the
// rho rotation offset for the lane currently presented on the output.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input lane valid
//   in_ready_o   block accepts an input lane (LOAD only)
//   in_high_i    lane bits [63:32]
//   in_low_i     lane bits [31:0]
//   out_valid_o  output lane valid (DRAIN only)
//   out_ready_i  downstream accepts the output lane
//   out_high_o   theta result bits [63:32], 0 when not valid
//   out_low_o    theta result bits [31:0], 0 when not valid
//   out_idx_o    lane index 0..24, 0 when not valid
//   busy_o       high in CALC or DRAIN
//   rot_off_o    rho offset for out_idx_o, 0 when not valid (macro only)
module keccak_theta_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_high_i,
  input  logic [31:0] in_low_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_high_o,
  output logic [31:0] out_low_o,
  output logic [4:0]  out_idx_o,
  output logic        busy_o
`ifdef KECCAK_THETA_RHO_OFF_EN
  ,
  output logic [5:0]  rot_off_o
`endif
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  // col tracks cnt mod 5 so the D-term lookup needs no divider
  logic [2:0]  col;
  logic [63:0] lane_buf [0:24];
  logic [63:0] d_term   [0:4];
  logic [63:0] d_nxt    [0:4];
  logic [63:0] col_par  [0:4];
  logic        in_hs, out_hs;
  logic [63:0] lane_out;

  function automatic logic [63:0] rol1(input logic [63:0] v);
    rol1 = {v[62:0], v[63]};
  endfunction

  assign in_hs  = in_valid_i & in_ready_o;
  assign out_hs = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && cnt == 5'd24) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i && cnt == 5'd24) state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  assign busy_o = (state != LOAD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      col <= '0;
    end else if (in_hs || out_hs) begin
      if (cnt == 5'd24) begin
        cnt <= '0;
        col <= '0;
      end else begin
        cnt <= cnt + 5'd1;
        col <= (col == 3'd4) ? 3'd0 : col + 3'd1;
      end
    end
  end

  // Lane storage is not reset; every entry is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (in_hs) lane_buf[cnt] <= {in_high_i, in_low_i};
  end

  always_comb begin
    for (int unsigned x = 0; x < 5; x++) begin
      col_par[x] = '0;
      for (int unsigned y = 0; y < 5; y++) begin
        col_par[x] = col_par[x] ^ lane_buf[x + 5 * y];
      end
    end
    for (int unsigned x = 0; x < 5; x++) begin
      d_nxt[x] = col_par[(x + 4) % 5] ^ rol1(col_par[(x + 1) % 5]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned x = 0; x < 5; x++) d_term[x] <= '0;
    end else if (state == CALC) begin
      for (int unsigned x = 0; x < 5; x++) d_term[x] <= d_nxt[x];
    end
  end

  assign lane_out   = lane_buf[cnt] ^ d_term[col];
  assign out_high_o = out_valid_o ? lane_out[63:32] : '0;
  assign out_low_o  = out_valid_o ? lane_out[31:0]  : '0;
  assign out_idx_o  = out_valid_o ? cnt : '0;

`ifdef KECCAK_THETA_RHO_OFF_EN
  logic [5:0] rho_off;

  always_comb begin
    rho_off = '0;
    case (cnt)
      5'd0:  rho_off = 6'd0;
      5'd1:  rho_off = 6'd1;
      5'd2:  rho_off = 6'd62;
      5'd3:  rho_off = 6'd28;
      5'd4:  rho_off = 6'd27;
      5'd5:  rho_off = 6'd36;
      5'd6:  rho_off = 6'd44;
      5'd7:  rho_off = 6'd6;
      5'd8:  rho_off = 6'd55;
      5'd9:  rho_off = 6'd20;
      5'd10: rho_off = 6'd3;
      5'd11: rho_off = 6'd10;
      5'd12: rho_off = 6'd43;
      5'd13: rho_off = 6'd25;
      5'd14: rho_off = 6'd39;
      5'd15: rho_off = 6'd41;
      5'd16: rho_off = 6'd45;
      5'd17: rho_off = 6'd15;
      5'd18: rho_off = 6'd21;
      5'd19: rho_off = 6'd8;
      5'd20: rho_off = 6'd18;
      5'd21: rho_off = 6'd2;
      5'd22: rho_off = 6'd61;
      5'd23: rho_off = 6'd56;
      5'd24: rho_off = 6'd14;
      default: rho_off = '0;
    endcase
  end

  assign rot_off_o = out_valid_o ? rho_off : '0;
`endif

endmodule

// File: tb/tb_keccak_theta_seq.sv
// Testbench for keccak_theta_seq: directed states plus randomized handshakes,
// with a queue of expected output lanes built from an independent theta model.
module tb_keccak_theta_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_high, in_low;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_high, out_low;
  logic [4:0]  out_idx;
  logic        busy;
`ifdef KECCAK_THETA_RHO_OFF_EN
  logic [5:0]  rot_off;
  int          rho_tab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                                25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
`endif

  always #5 clk = ~clk;

  keccak_theta_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_high_i   (in_high),
    .in_low_i    (in_low),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_high_o  (out_high),
    .out_low_o   (out_low),
    .out_idx_o   (out_idx),
    .busy_o      (busy)
`ifdef KECCAK_THETA_RHO_OFF_EN
    ,
    .rot_off_o   (rot_off)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [68:0] sb [$];
  logic [63:0] st [25];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference theta on st[], pushed lane by lane into the scoreboard.
  task automatic push_model();
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] r;
    for (int x = 0; x < 5; x++) begin
      c[x] = st[x] ^ st[x + 5] ^ st[x + 10] ^ st[x + 15] ^ st[x + 20];
    end
    for (int x = 0; x < 5; x++) begin
      r = c[(x + 1) % 5];
      d[x] = c[(x + 4) % 5] ^ {r[62:0], r[63]};
    end
    for (int i = 0; i < 25; i++) begin
      sb.push_back({i[4:0], st[i] ^ d[i % 5]});
    end
  endtask

  // Hand-derived expectations for a single-lane-0 input: x=0 -> v0, x=1 -> v1, x=4 -> v4.
  task automatic push_fixed(input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v4);
    logic [63:0] e;
    for (int i = 0; i < 25; i++) begin
      e = '0;
      if (i == 0) e = v0;
      else if (i % 5 == 1) e = v1;
      else if (i % 5 == 4) e = v4;
      sb.push_back({i[4:0], e});
    end
  endtask

  task automatic load_state(input bit gaps, input bit hold_valid);
    bit rdy, accepted;
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_high  = $urandom;
          in_low   = $urandom;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_high  = st[i][63:32];
      in_low   = st[i][31:0];
      accepted = 1'b0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        accepted = rdy;
      end
      chk("load_accept", {71'd0, accepted}, 72'd1);
    end
    if (hold_valid) begin
      in_high = 32'hDEAD_BEEF;
      in_low  = 32'hCAFE_F00D;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("calc_out_valid", {71'd0, out_valid}, 72'd0);
    chk("calc_in_ready",  {71'd0, in_ready},  72'd0);
    chk("calc_busy",      {71'd0, busy},      72'd1);
  endtask

  task automatic drain(input bit toggle, input int n);
    int          got = 0;
    int          budget = 0;
    bit          stalled = 1'b0;
    bit          first = 1'b1;
    logic [68:0] prev = '0;
    logic [68:0] e;
    out_ready = 1'b0;
    while (got < n && budget < 200) begin
      @(posedge clk); #1;
      out_ready = toggle ? ~out_ready : 1'b1;
      @(negedge clk);
      budget++;
      if (first) begin
        chk("first_valid_latency", {71'd0, out_valid}, 72'd1);
        first = 1'b0;
      end
      if (!out_valid) begin
        chk("drain_valid_held", {71'd0, out_valid}, 72'd1);
      end else begin
        chk("drain_in_ready", {71'd0, in_ready}, 72'd0);
        chk("drain_busy",     {71'd0, busy},     72'd1);
        if (stalled) chk("stall_stable", {3'd0, out_idx, out_high, out_low}, {3'd0, prev});
        if (out_ready) begin
          chk("sb_nonempty", {71'd0, sb.size() != 0}, 72'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_idx",  {67'd0, out_idx}, {67'd0, e[68:64]});
            chk("out_lane", {8'd0, out_high, out_low}, {8'd0, e[63:0]});
`ifdef KECCAK_THETA_RHO_OFF_EN
            chk("rot_off", {66'd0, rot_off}, 72'(rho_tab[e[68:64]]));
`endif
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = {out_idx, out_high, out_low};
        end
      end
    end
    chk("drain_count", 72'(got), 72'(n));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, {71'd0, out_valid}, 72'd0);
    chk({tag, "_in_ready"},  {71'd0, in_ready},  72'd1);
    chk({tag, "_busy"},      {71'd0, busy},      72'd0);
    chk({tag, "_data"}, {3'd0, out_idx, out_high, out_low}, 72'd0);
`ifdef KECCAK_THETA_RHO_OFF_EN
    chk({tag, "_rot_off"}, {66'd0, rot_off}, 72'd0);
`endif
  endtask

  task automatic finish_drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle("post_drain");
  endtask

  task automatic rand_state();
    for (int i = 0; i < 25; i++) st[i] = {$urandom, $urandom};
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_high   = '0;
    in_low    = '0;
    out_ready = 1'b0;
    #3;
    check_idle("reset");
    #9 rst_n = 1'b1;

    // all-zero state
    for (int i = 0; i < 25; i++) st[i] = '0;
    push_fixed(64'd0, 64'd0, 64'd0);
    load_state(1'b0, 1'b0);
    drain(1'b0, 25);
    finish_drain();

    // single low bit in lane 0
    st[0] = 64'h0000_0000_0000_0001;
    push_fixed(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002);
    load_state(1'b0, 1'b0);
    drain(1'b0, 25);
    finish_drain();

    // top bit in lane 0: rotate wraps bit 63 into bit 0
    st[0] = 64'h8000_0000_0000_0000;
    push_fixed(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001);
    load_state(1'b0, 1'b0);
    drain(1'b0, 25);
    finish_drain();

    // bit 31 must cross into bit 32 of the rotated parity
    for (int i = 0; i < 25; i++) st[i] = '0;
    st[2] = 64'h0000_0000_8000_0000;
    push_model();
    load_state(1'b0, 1'b0);
    drain(1'b0, 25);
    finish_drain();

    // random state, input gaps, out_ready toggling, in_valid held during CALC/DRAIN
    for (int k = 0; k < 2; k++) begin
      rand_state();
      push_model();
      load_state(1'b1, 1'b1);
      drain(1'b1, 25);
      finish_drain();
    end

    // reset after 10 output lanes
    rand_state();
    push_model();
    load_state(1'b0, 1'b0);
    drain(1'b0, 10);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_mid_out_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_mid_in_ready",  {71'd0, in_ready},  72'd1);
    chk("rst_mid_busy",      {71'd0, busy},      72'd0);
    sb.delete();
    #2 rst_n = 1'b1;

    // full state after the reset starts cleanly from idx 0
    rand_state();
    push_model();
    load_state(1'b1, 1'b0);
    drain(1'b1, 25);
    finish_drain();

    chk("sb_empty_at_end", 72'(sb.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
